npu_result_tx: RTL and testbench

Result-return transmitter of the NPU: captures result words written by the compute core into a flop-based buffer, raises `result_is_OK_o` once the core signals completion, then streams the words out on a valid/ready interface framed by `sop_o`/`eop_o`. It is the output-side counterpart of the `valid_i`/`sop_i`/`eop_i`/`data_in_i` load protocol and sits between the compute core and the NPU top-level output ports.

---
 rtl/npu_result_tx.sv | 140 ++++++++++++++
 tb/tb_npu_result_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/npu_result_tx.sv
// rtl/npu_result_tx.sv - NPU result buffer and framed valid/ready burst transmitter
// Optional feature macro: NPU_RESULT_TX_CHECKSUM_EN (appends a wrap-around sum word to each burst)
module npu_result_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  done_i,
  input  logic [AW:0]           len_i,
  output logic                  result_is_OK_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  sop_o,
  output logic                  eop_o
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SEND} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           len_q, len_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]           last_idx;
  logic                  valid_q, valid_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic                  ok_q, ok_d;
  logic                  xfer;
  logic                  accept_done;
  logic [DATA_WIDTH-1:0] word_sel;

  // A zero-length completion is dropped so the block never enters HOLD with nothing to send.
  assign accept_done = (state_q == S_IDLE) && done_i && (len_i != '0);
  assign xfer        = valid_q & ready_i;

`ifdef NPU_RESULT_TX_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;

  // The checksum beat sits at index len, one past the last data word.
  assign last_idx = len_q;
  assign word_sel = (rd_ptr_q == len_q) ? sum_q : mem_q[rd_ptr_q[AW-1:0]];

  // Running sum of data words actually handed downstream; restarts with every new burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (accept_done) begin
      sum_q <= '0;
    end else if (xfer && (rd_ptr_q != len_q)) begin
      sum_q <= sum_q + word_sel;
    end
  end
`else
  assign last_idx = len_q - (AW+1)'(1);
  assign word_sel = mem_q[rd_ptr_q[AW-1:0]];
`endif

  // Data is forced to zero outside a valid beat so reset and idle present a clean bus.
  assign data_out_o = valid_q ? word_sel : '0;

  // Result buffer: only writable while idle so an in-flight burst is never disturbed.
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      ok_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      ok_q     <= ok_d;
    end
  end

  // Next-state logic: latch the clamped length, wait for the first ready, then walk the buffer.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rd_ptr_d = rd_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (accept_done) begin
          state_d  = S_HOLD;
          len_d    = (len_i > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len_i;
          rd_ptr_d = '0;
        end
      end
      S_HOLD: begin
        if (ready_i) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (rd_ptr_q == last_idx) begin
            state_d  = S_IDLE;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every framing output comes straight from a flop.
  always_comb begin
    ok_d    = (state_d != S_IDLE);
    valid_d = (state_d == S_SEND);
    sop_d   = valid_d && (rd_ptr_d == '0);
    eop_d   = valid_d && (rd_ptr_d == last_idx);
  end

  assign result_is_OK_o = ok_q;
  assign valid_o        = valid_q;
  assign sop_o          = sop_q;
  assign eop_o          = eop_q;

endmodule

// File: tb/tb_npu_result_tx.sv
// tb/tb_npu_result_tx.sv - directed and randomized burst checks for npu_result_tx
module tb_npu_result_tx;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef logic [DW-1:0] wq_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          done = 1'b0;
  logic [AW:0]   len_in = '0;
  logic          ready = 1'b0;
  logic          ok;
  logic          valid;
  logic [DW-1:0] data_out;
  logic          sop;
  logic          eop;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q [$];

  npu_result_tx #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en_i(wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .done_i(done),
    .len_i(len_in),
    .result_is_OK_o(ok),
    .valid_o(valid),
    .ready_i(ready),
    .data_out_o(data_out),
    .sop_o(sop),
    .eop_o(eop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic wq_t rand_words(input int n);
    wq_t q;
    for (int i = 0; i < n; i++) q.push_back(DW'($urandom));
    return q;
  endfunction

  // Write words to addresses 0..n-1, the final write coinciding with done; build the expected burst.
  task automatic load(input wq_t words, input int n_len);
    int nw;
    logic [DW-1:0] s;
    nw = (n_len > DEPTH) ? DEPTH : n_len;
    s = '0;
    for (int i = 0; i < nw; i++) begin
      wr_en = 1'b1;
      wr_addr = AW'(i);
      wr_data = words[i];
      mem[i] = words[i];
      if (i == nw - 1) begin
        done = 1'b1;
        len_in = (AW+1)'(n_len);
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    done = 1'b0;
    exp_q.delete();
    for (int i = 0; i < nw; i++) begin
      exp_q.push_back(mem[i]);
      s = s + mem[i];
    end
`ifdef NPU_RESULT_TX_CHECKSUM_EN
    exp_q.push_back(s);
`endif
  endtask

  // mode 0: ready held high, 1: toggling starting high, 2: random. intrude: write+done during transfer.
  task automatic run_burst(input int mode, input bit intrude);
    int idx;
    int n;
    int cyc;
    bit xf;
    idx = 0;
    cyc = 0;
    n = exp_q.size();
    check("ok_rise", 32'(ok), 32'd1);
    check("hold_valid", 32'(valid), 32'd0);
    while (idx < n && cyc < 400) begin
      if (valid) begin
        check("data", 32'(data_out), 32'(exp_q[idx]));
        check("sop", 32'(sop), 32'(idx == 0));
        check("eop", 32'(eop), 32'(idx == n - 1));
        check("ok_send", 32'(ok), 32'd1);
      end else begin
        check("ok_wait", 32'(ok), 32'd1);
      end
      case (mode)
        0: ready = 1'b1;
        1: ready = (cyc % 2 == 0);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (intrude && cyc == 2) begin
        wr_en = 1'b1;
        wr_addr = AW'(2);
        wr_data = ~mem[2];
        done = 1'b1;
        len_in = (AW+1)'(3);
      end
      xf = valid && ready;
      @(negedge clk);
      wr_en = 1'b0;
      done = 1'b0;
      cyc++;
      if (xf) idx++;
    end
    check("burst_words", 32'(idx), 32'(n));
    if (mode == 0) check("burst_cycles", 32'(cyc), 32'(n + 1));
    ready = 1'b0;
    check("end_valid", 32'(valid), 32'd0);
    check("end_ok", 32'(ok), 32'd0);
    check("end_sop", 32'(sop), 32'd0);
    check("end_eop", 32'(eop), 32'd0);
    if (intrude) begin
      @(negedge clk);
      check("intrude_no_ok", 32'(ok), 32'd0);
    end
  endtask

  initial begin
    wq_t w;
    int ln;

    // Reset state
    @(negedge clk);
    check("rst_ok", 32'(ok), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_sop", 32'(sop), 32'd0);
    check("rst_eop", 32'(eop), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ok", 32'(ok), 32'd0);

    // Basic 4-word burst, ready held high
    w = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    load(w, 4);
    run_burst(0, 1'b0);

    // Same load with ready toggling
    load(w, 4);
    run_burst(1, 1'b0);

    // Single-word burst
    w = '{16'hBEEF};
    load(w, 1);
    run_burst(0, 1'b0);

    // Zero length is ignored
    done = 1'b1;
    len_in = '0;
    @(negedge clk);
    done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("len0_ok", 32'(ok), 32'd0);
      check("len0_valid", 32'(valid), 32'd0);
      @(negedge clk);
    end

    // Oversized length clamps to DEPTH
    load(rand_words(DEPTH), DEPTH + 1);
    run_burst(2, 1'b0);

    // Writes and done during transfer are ignored
    load(rand_words(4), 4);
    run_burst(0, 1'b1);

    // Reset in the middle of a burst
    load(rand_words(4), 4);
    ready = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_valid", 32'(valid), 32'd1);
    check("mid_data", 32'(data_out), 32'(exp_q[2]));
    rst_n = 1'b0;
    ready = 1'b0;
    #1;
    check("arst_ok", 32'(ok), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_sop", 32'(sop), 32'd0);
    check("arst_eop", 32'(eop), 32'd0);
    check("arst_data", 32'(data_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ok", 32'(ok), 32'd0);
    load(rand_words(3), 3);
    run_burst(2, 1'b0);

    // Wrap-around values (checksum case when enabled)
    w = '{16'hFFFF, 16'h0002};
    load(w, 2);
    run_burst(0, 1'b0);

    // Randomized bursts
    for (int k = 0; k < 6; k++) begin
      ln = $urandom_range(1, DEPTH + 3);
      load(rand_words(ln > DEPTH ? DEPTH : ln), ln);
      run_burst($urandom_range(0, 2), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
